operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
- Upstream feeder for the ALU operand registers (BIT_COUNT-wide latch banks with a level `store` enable).
- Accepts a serial stream of words over a valid/ready handshake: opcode, then operand A, then operand B.
- Drives the shared register data bus and a held store strobe per register, then issues the opcode to the ALU and waits for completion.

Parameters:
- BIT_COUNT, 8, width of data words and operand registers.
- OPCODE_BITS, 3, opcode width, taken from in_data[OPCODE_BITS-1:0]; must be <= BIT_COUNT.
- STORE_CYCLES, 2, number of cycles each store strobe is held high; must be >= 1.

Ports:
- clk  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  BIT_COUNT  incoming word (opcode, A or B, by sequence position).
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a word this cycle.
- reg_data  output  BIT_COUNT  data bus to the operand registers.
- store_a  output  1  store enable for operand register A.
- store_b  output  1  store enable for operand register B.
- opcode  output  OPCODE_BITS  latched opcode for the ALU.
- op_valid  output  1  operands loaded, ALU may execute.
- op_ready  input  1  ALU has consumed the operation.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, reg_data=0, store_a=0, store_b=0, opcode=0, op_valid=0, busy=0, hold counter=0.
- Transfer occurs on a rising edge with in_valid && in_ready. in_ready is combinational from state only: 1 in IDLE, GET_A and GET_B; 0 otherwise.
- IDLE: on transfer, latch opcode <= in_data[OPCODE_BITS-1:0], go to GET_A.
- GET_A: on transfer, reg_data <= in_data, counter <= STORE_CYCLES-1, go to STORE_A.
- STORE_A: store_a=1. Decrement the counter each cycle; at 0 go to GET_B. store_a is high for exactly STORE_CYCLES cycles.
- GET_B and STORE_B: identical to GET_A and STORE_A, using store_b. STORE_B exits to ISSUE.
- ISSUE: op_valid=1, held until op_ready is sampled high; then op_valid drops and the state returns to IDLE the next cycle.
- Strobe rules:
  - store_a and store_b are registered outputs.
  - They are never high simultaneously.
  - reg_data is stable for the whole strobe and holds its last value after it; it changes only on a GET_x transfer.
- No word is accepted in STORE_x or ISSUE. An upstream word is held by the producer (valid stays asserted).
- op_ready asserted outside ISSUE: ignored.
- in_valid deasserted in a GET_x state: wait indefinitely, outputs unchanged.
- Reset asserted mid-sequence: strobes drop immediately (async) and the partial operation is discarded.
- Total latency from the opcode transfer to op_valid, with in_valid held continuously high: 2*(STORE_CYCLES+1)+1 cycles. This is 7 with the defaults.

Optional Feature:
- Macro: OPERAND_LOADER_UNARY_EN.
- Defined: an opcode with bit OPCODE_BITS-1 set is unary. STORE_A exits directly to ISSUE, and GET_B/STORE_B are skipped with store_b never asserted. Unary latency is STORE_CYCLES+2.
- Undefined: all opcodes load both operands; the opcode MSB has no special meaning.

Decomposition:
- Shared package holds:
  - the state enum typedef (IDLE, GET_A, STORE_A, GET_B, STORE_B, ISSUE);
  - default width constants for BIT_COUNT and OPCODE_BITS;
  - the opcode typedef and unary-bit index constant, shared with the ALU decoder.
- Sub-module: store_pulse_timer. It loads STORE_CYCLES-1, counts down, and flags done. It is instantiated once and reused for both strobes.

Test Plan:
- Reset with in_valid=1 -> all outputs 0, in_ready=1 on the first cycle after reset_n rises.
- Stream 0x05, 0x3C, 0xA1 with in_valid always high -> opcode=5; store_a high 2 cycles with reg_data=0x3C; store_b high 2 cycles with reg_data=0xA1; op_valid on cycle 7.
- Hold op_ready=0 for 10 cycles in ISSUE -> op_valid held, in_ready=0, word 0x11 on in_data not consumed; op_ready=1 -> IDLE next cycle, then 0x11 is accepted as the next opcode.
- Gap on in_valid during GET_B for 5 cycles -> store_b stays 0, reg_data stays 0x3C, busy=1.
- reset_n low during STORE_A -> store_a falls within the same cycle; after release, 0x02, 0x10, 0x20 loads cleanly.
- With OPERAND_LOADER_UNARY_EN, opcode 0x04, A=0x7F -> store_b never asserted, op_valid on cycle 4; without the macro -> a full three-word sequence is required.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader and the ALU opcode decoder.
package operand_loader_pkg;

    localparam int unsigned DEF_BIT_COUNT    = 8;
    localparam int unsigned DEF_OPCODE_BITS  = 3;
    // Opcode bit that marks a single-operand operation when unary support is built in.
    localparam int unsigned OPCODE_UNARY_BIT = DEF_OPCODE_BITS - 1;

    typedef logic [DEF_OPCODE_BITS-1:0] opcode_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_A   = 3'd1,
        STORE_A = 3'd2,
        GET_B   = 3'd3,
        STORE_B = 3'd4,
        ISSUE   = 3'd5
    } state_t;

    // True when the opcode only needs operand A.
    function automatic logic is_unary(input opcode_t op);
        return op[OPCODE_UNARY_BIT];
    endfunction

endpackage

// File: rtl/operand_loader_store_pulse_timer.sv
// Down-counter that times how long a store strobe stays high; shared by both strobes.
module store_pulse_timer #(
    parameter int unsigned STORE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_dec,
    output logic o_done_c
);

    localparam int unsigned CNT_W = (STORE_CYCLES > 1) ? $clog2(STORE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(STORE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Load on operand capture, then count down to zero while the strobe is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/operand_loader.sv
// Serial opcode/A/B loader feeding the ALU operand latch banks.
// Optional: define OPERAND_LOADER_UNARY_EN so opcodes with the MSB set skip operand B.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int unsigned BIT_COUNT    = DEF_BIT_COUNT,
    parameter int unsigned OPCODE_BITS  = DEF_OPCODE_BITS,
    parameter int unsigned STORE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [BIT_COUNT-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [BIT_COUNT-1:0]   reg_data,
    output logic                   store_a,
    output logic                   store_b,
    output logic [OPCODE_BITS-1:0] opcode,
    output logic                   op_valid,
    input  logic                   op_ready,
    output logic                   busy
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [BIT_COUNT-1:0]   r_reg_data;
    logic [BIT_COUNT-1:0]   w_reg_data_nxt;
    logic [OPCODE_BITS-1:0] r_opcode;
    logic [OPCODE_BITS-1:0] w_opcode_nxt;
    logic                   r_store_a;
    logic                   r_store_b;
    logic                   r_op_valid;
    logic                   r_busy;
    logic                   w_in_ready;
    logic                   w_xfer;
    logic                   w_load;
    logic                   w_dec;
    logic                   w_done;

    store_pulse_timer #(
        .STORE_CYCLES (STORE_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_load   (w_load),
        .i_dec    (w_dec),
        .o_done_c (w_done)
    );

    // Words are accepted only in states that expect the next stream word.
    assign w_in_ready = (r_state == IDLE) || (r_state == GET_A) || (r_state == GET_B);
    assign w_xfer     = in_valid && w_in_ready;

    // Next-state, data capture and timer control.
    always_comb begin
        w_state_nxt    = r_state;
        w_reg_data_nxt = r_reg_data;
        w_opcode_nxt   = r_opcode;
        w_load         = 1'b0;
        w_dec          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_opcode_nxt = in_data[OPCODE_BITS-1:0];
                    w_state_nxt  = GET_A;
                end
            end
            GET_A: begin
                if (w_xfer) begin
                    w_reg_data_nxt = in_data;
                    w_load         = 1'b1;
                    w_state_nxt    = STORE_A;
                end
            end
            STORE_A: begin
                if (w_done) begin
`ifdef OPERAND_LOADER_UNARY_EN
                    w_state_nxt = r_opcode[OPCODE_BITS-1] ? ISSUE : GET_B;
`else
                    w_state_nxt = GET_B;
`endif
                end else begin
                    w_dec = 1'b1;
                end
            end
            GET_B: begin
                if (w_xfer) begin
                    w_reg_data_nxt = in_data;
                    w_load         = 1'b1;
                    w_state_nxt    = STORE_B;
                end
            end
            STORE_B: begin
                if (w_done) begin
                    w_state_nxt = ISSUE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ISSUE: begin
                if (op_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; strobes follow the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_reg_data <= '0;
            r_opcode   <= '0;
            r_store_a  <= 1'b0;
            r_store_b  <= 1'b0;
            r_op_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_reg_data <= w_reg_data_nxt;
            r_opcode   <= w_opcode_nxt;
            r_store_a  <= (w_state_nxt == STORE_A);
            r_store_b  <= (w_state_nxt == STORE_B);
            r_op_valid <= (w_state_nxt == ISSUE);
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    assign in_ready = w_in_ready;
    assign reg_data = r_reg_data;
    assign opcode   = r_opcode;
    assign store_a  = r_store_a;
    assign store_b  = r_store_b;
    assign op_valid = r_op_valid;
    assign busy     = r_busy;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: per-cycle vector table plus multi-cycle sequences.
module tb_operand_loader;

    localparam int unsigned SC = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] reg_data;
    logic       store_a;
    logic       store_b;
    logic [2:0] opcode;
    logic       op_valid;
    logic       op_ready;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    operand_loader #(
        .BIT_COUNT    (8),
        .OPCODE_BITS  (3),
        .STORE_CYCLES (SC)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .reg_data (reg_data),
        .store_a  (store_a),
        .store_b  (store_b),
        .opcode   (opcode),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .busy     (busy)
    );

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       r;
        logic       sa;
        logic       sb;
        logic [7:0] rd;
        logic [2:0] oc;
        logic       ov;
        logic       bz;
        logic       ir;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic v, input logic r,
                                input logic sa, input logic sb, input logic [7:0] rd,
                                input logic [2:0] oc, input logic ov, input logic bz,
                                input logic ir);
        vec_t x;
        x.d = d; x.v = v; x.r = r; x.sa = sa; x.sb = sb; x.rd = rd;
        x.oc = oc; x.ov = ov; x.bz = bz; x.ir = ir;
        return x;
    endfunction

    task automatic check_all(input string tag, input logic sa, input logic sb,
                             input logic [7:0] rd, input logic [2:0] oc, input logic ov,
                             input logic bz, input logic ir);
        chk({tag, "_store_a"},  32'(store_a),  32'(sa));
        chk({tag, "_store_b"},  32'(store_b),  32'(sb));
        chk({tag, "_reg_data"}, 32'(reg_data), 32'(rd));
        chk({tag, "_opcode"},   32'(opcode),   32'(oc));
        chk({tag, "_op_valid"}, 32'(op_valid), 32'(ov));
        chk({tag, "_busy"},     32'(busy),     32'(bz));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(ir));
    endtask

    // Streams nwords words with a producer that honours in_ready, then measures the result.
    task automatic run_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int nwords, input int exp_sb, input int exp_lat,
                          input string tag);
        logic [7:0] w [3];
        int idx    = 0;
        int e      = -1;
        int sa_n   = 0;
        int sb_n   = 0;
        int bad_rd = 0;
        int both   = 0;
        int lat    = 0;
        logic xfer;
        w[0] = op; w[1] = a; w[2] = b;
        op_ready = 1'b0;
        for (int c = 0; c < 40 && lat == 0; c++) begin
            if (idx < nwords) begin
                in_valid = 1'b1;
                in_data  = w[idx];
            end else begin
                in_valid = 1'b0;
                in_data  = 8'h00;
            end
            xfer = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (e >= 0) e++;
            if (xfer) begin
                if (idx == 0) e = 0;
                idx++;
            end
            if (store_a) begin
                sa_n++;
                if (reg_data !== a) bad_rd++;
            end
            if (store_b) begin
                sb_n++;
                if (reg_data !== b) bad_rd++;
            end
            if (store_a && store_b) both++;
            if (op_valid && e >= 0) lat = e + 1;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"},      32'(lat),    32'(exp_lat));
        chk({tag, "_words_taken"},  32'(idx),    32'(nwords));
        chk({tag, "_store_a_len"},  32'(sa_n),   32'(SC));
        chk({tag, "_store_b_len"},  32'(sb_n),   32'(exp_sb));
        chk({tag, "_strobe_data"},  32'(bad_rd), 32'(0));
        chk({tag, "_strobe_both"},  32'(both),   32'(0));
        chk({tag, "_opcode"},       32'(opcode), 32'(op[2:0]));
        if (lat != 0) begin
            op_ready = 1'b1;
            @(posedge clk);
            #1;
            op_ready = 1'b0;
            chk({tag, "_done_op_valid"}, 32'(op_valid), 32'(0));
            chk({tag, "_done_busy"},     32'(busy),     32'(0));
            chk({tag, "_done_in_ready"}, 32'(in_ready), 32'(1));
        end
    endtask

    initial begin
        logic [7:0] op_main;
        logic [2:0] oc;
`ifdef OPERAND_LOADER_UNARY_EN
        op_main = 8'h03;
`else
        op_main = 8'h05;
`endif
        oc = op_main[2:0];

        // Reset with a word already waiting upstream.
        reset_n  = 1'b0;
        in_data  = op_main;
        in_valid = 1'b1;
        op_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_all("reset", 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);

        // Full three-word load with in_valid held high.
        tbl.push_back(mk(op_main, 1, 0, 0, 0, 8'h00, oc, 0, 1, 1));
        tbl.push_back(mk(8'h3C,   1, 0, 1, 0, 8'h3C, oc, 0, 1, 0));
        tbl.push_back(mk(8'hA1,   1, 0, 1, 0, 8'h3C, oc, 0, 1, 0));
        tbl.push_back(mk(8'hA1,   1, 0, 0, 0, 8'h3C, oc, 0, 1, 1));
        tbl.push_back(mk(8'hA1,   1, 0, 0, 1, 8'hA1, oc, 0, 1, 0));
        tbl.push_back(mk(8'h11,   1, 0, 0, 1, 8'hA1, oc, 0, 1, 0));
        tbl.push_back(mk(8'h11,   1, 0, 0, 0, 8'hA1, oc, 1, 1, 0));
        // ALU stalls for 10 cycles; the waiting word 0x11 must not be taken.
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(8'h11, 1, 0, 0, 0, 8'hA1, oc, 1, 1, 0));
        tbl.push_back(mk(8'h11,   1, 1, 0, 0, 8'hA1, oc, 0, 0, 1));
        tbl.push_back(mk(8'h11,   1, 0, 0, 0, 8'hA1, 3'd1, 0, 1, 1));
        // Operand A, then a 5-cycle gap while waiting for B.
        tbl.push_back(mk(8'h3C,   1, 0, 1, 0, 8'h3C, 3'd1, 0, 1, 0));
        tbl.push_back(mk(8'h3C,   0, 0, 1, 0, 8'h3C, 3'd1, 0, 1, 0));
        tbl.push_back(mk(8'h3C,   0, 0, 0, 0, 8'h3C, 3'd1, 0, 1, 1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(8'h99, 0, 0, 0, 0, 8'h3C, 3'd1, 0, 1, 1));
        // op_ready high before ISSUE is ignored.
        tbl.push_back(mk(8'h77,   1, 1, 0, 1, 8'h77, 3'd1, 0, 1, 0));
        tbl.push_back(mk(8'h77,   1, 1, 0, 1, 8'h77, 3'd1, 0, 1, 0));
        tbl.push_back(mk(8'h77,   1, 1, 0, 0, 8'h77, 3'd1, 1, 1, 0));
        tbl.push_back(mk(8'h00,   0, 1, 0, 0, 8'h77, 3'd1, 0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            in_data  = tbl[i].d;
            in_valid = tbl[i].v;
            op_ready = tbl[i].r;
            @(posedge clk);
            #1;
            check_all($sformatf("row%0d", i), tbl[i].sa, tbl[i].sb, tbl[i].rd,
                      tbl[i].oc, tbl[i].ov, tbl[i].bz, tbl[i].ir);
        end
        in_valid = 1'b0;
        op_ready = 1'b0;

        // Reset in the middle of STORE_A drops the strobe without waiting for a clock.
        in_data  = 8'h02;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_data = 8'h55;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("midreset_store_a_before", 32'(store_a), 32'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check_all("midreset", 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(8'h02, 8'h10, 8'h20, 3, 2, 7, "after_reset");

`ifdef OPERAND_LOADER_UNARY_EN
        run_op(8'h04, 8'h7F, 8'h00, 2, 0, SC + 2, "unary");
`else
        run_op(8'h04, 8'h7F, 8'hB2, 3, 2, 7, "msb_op");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
